// File: rtl/aes_drv_pkg.sv
// Shared types and constants for the AES job driver.
package aes_drv_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_LOAD_D,
    S_LOAD_K,
    S_START,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_HOLD
  } drv_state_e;

  localparam int WORDS_PER_BLK = 4;
  localparam int KEY_SEL_BIT   = 16;

  // no_of_words doubles as the bridge read select outside the start cycle
  localparam logic [9:0] RDSEL_OUT  = 10'd0;
  localparam logic [9:0] RDSEL_KEY  = 10'd1;
  localparam logic [9:0] RDSEL_DATA = 10'd2;

endpackage

// File: rtl/aes_drv_addr_gen.sv
// Block/word/read counters and byte-address generation for the
// DATA, KEY and OUT bridge regions.
module aes_drv_addr_gen
  import aes_drv_pkg::*;
#(
  parameter logic [15:0] DATA_BASE = 16'h0000,
  parameter logic [15:0] KEY_BASE  = 16'h0000,
  parameter logic [15:0] OUT_BASE  = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        w_inc_i,
  input  logic        b_inc_i,
  input  logic        r_clr_i,
  input  logic        r_inc_i,
  output logic [1:0]  w_o,
  output logic [9:0]  b_o,
  output logic [11:0] r_o,
  output logic [15:0] data_addr_o,
  output logic [15:0] key_addr_o,
  output logic [15:0] out_addr_o
);

  logic [1:0]  w_q, w_d;
  logic [9:0]  b_q, b_d;
  logic [11:0] r_q, r_d;

  // Next counter values; the word counter wraps naturally at a block boundary.
  always_comb begin
    w_d = w_q;
    b_d = b_q;
    r_d = r_q;
    if (clr_i) begin
      w_d = 2'd0;
      b_d = 10'd0;
    end else begin
      if (w_inc_i) w_d = w_q + 2'd1;
      if (b_inc_i) b_d = b_q + 10'd1;
    end
    if (r_clr_i)      r_d = 12'd0;
    else if (r_inc_i) r_d = r_q + 12'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_q <= 2'd0;
      b_q <= 10'd0;
      r_q <= 12'd0;
    end else begin
      w_q <= w_d;
      b_q <= b_d;
      r_q <= r_d;
    end
  end

  assign w_o = w_q;
  assign b_o = b_q;
  assign r_o = r_q;

  // 16 bytes per block, 4 bytes per word
  assign data_addr_o = DATA_BASE + {2'b00, b_q, 4'b0000} + {12'd0, w_q, 2'b00};
  assign key_addr_o  = KEY_BASE  + {2'b00, b_q, 4'b0000} + {12'd0, w_q, 2'b00};
  assign out_addr_o  = OUT_BASE  + {2'b00, r_q, 2'b00};

endmodule

// File: rtl/aes_job_driver.sv
// Processor-side AES job driver: loads key/data into the bridge memories,
// fires one start pulse, waits a fixed time and streams the OUT memory back.
module aes_job_driver
  import aes_drv_pkg::*;
#(
  parameter logic [15:0] DATA_BASE    = 16'h0000,
  parameter logic [15:0] KEY_BASE     = 16'h0000,
  parameter logic [15:0] OUT_BASE     = 16'h0000,
  parameter int          MAX_BLOCKS   = 64,
  parameter int          RD_LAT       = 2,
  parameter int          WAIT_BASE    = 32,
  parameter int          WAIT_PER_BLK = 4
) (
  input  logic        clk_processor,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_decrypt,
  input  logic [9:0]  cmd_nblocks,
  output logic        cmd_err,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic        aes_encrypt,
  output logic        aes_decrypt,
  output logic        write_en,
  output logic [16:0] data_addr,
  output logic [15:0] key_addr,
  output logic [15:0] write_addr,
  output logic [31:0] write_data,
  output logic [9:0]  no_of_words,
  input  logic [31:0] read_data
);

  localparam logic [7:0] LAT_LAST = 8'(RD_LAT - 1);

  drv_state_e  state_q, state_d;
  logic        op_q;
  logic [9:0]  n_q;
  logic [31:0] key_q [WORDS_PER_BLK];
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  lat_q, lat_d;
  logic [31:0] out_data_q;
  logic        cmd_err_q, cmd_err_d;

  logic        latch_cmd, key_wr, capture;
  logic        ag_clr, ag_w_inc, ag_b_inc, ag_r_clr, ag_r_inc;
  logic [1:0]  w;
  logic [9:0]  b;
  logic [11:0] r;
  logic [15:0] data_wa, key_wa, out_ra;
  logic        cmd_bad, in_acc, rd_last;
  logic [15:0] wait_load;
  logic [11:0] last_idx;

  assign cmd_bad   = (cmd_nblocks == 10'd0) || (cmd_nblocks > 10'(MAX_BLOCKS));
  assign in_acc    = in_valid && ((state_q == S_KEY) || (state_q == S_LOAD_D));
  assign wait_load = 16'(WAIT_BASE) + 16'(n_q) * 16'(WAIT_PER_BLK);
  assign last_idx  = 12'(n_q) * 12'(WORDS_PER_BLK) - 12'd1;
  assign rd_last   = (r == last_idx);

  aes_drv_addr_gen #(
    .DATA_BASE (DATA_BASE),
    .KEY_BASE  (KEY_BASE),
    .OUT_BASE  (OUT_BASE)
  ) u_addr_gen (
    .clk_i       (clk_processor),
    .rst_i       (reset),
    .clr_i       (ag_clr),
    .w_inc_i     (ag_w_inc),
    .b_inc_i     (ag_b_inc),
    .r_clr_i     (ag_r_clr),
    .r_inc_i     (ag_r_inc),
    .w_o         (w),
    .b_o         (b),
    .r_o         (r),
    .data_addr_o (data_wa),
    .key_addr_o  (key_wa),
    .out_addr_o  (out_ra)
  );

  // Next-state and counter control for the job sequence.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    lat_d     = lat_q;
    cmd_err_d = 1'b0;
    latch_cmd = 1'b0;
    key_wr    = 1'b0;
    capture   = 1'b0;
    ag_clr    = 1'b0;
    ag_w_inc  = 1'b0;
    ag_b_inc  = 1'b0;
    ag_r_clr  = 1'b0;
    ag_r_inc  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          latch_cmd = 1'b1;
          if (cmd_bad) begin
            cmd_err_d = 1'b1;
          end else begin
            ag_clr  = 1'b1;
            state_d = S_KEY;
          end
        end
      end
      S_KEY: begin
        if (in_acc) begin
          key_wr   = 1'b1;
          ag_w_inc = 1'b1;
          if (w == 2'd3) state_d = S_LOAD_D;
        end
      end
      S_LOAD_D: begin
        if (in_acc) begin
          ag_w_inc = 1'b1;
          if (w == 2'd3) state_d = S_LOAD_K;
        end
      end
      S_LOAD_K: begin
        ag_w_inc = 1'b1;
        if (w == 2'd3) begin
          ag_b_inc = 1'b1;
          state_d  = ((b + 10'd1) == n_q) ? S_START : S_LOAD_D;
        end
      end
      S_START: begin
        wcnt_d  = wait_load;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Leaving on a count of 1 makes WAIT last exactly wait_load cycles
        wcnt_d = (wcnt_q != 16'd0) ? (wcnt_q - 16'd1) : 16'd0;
        if (wcnt_q <= 16'd1) begin
          ag_r_clr = 1'b1;
          lat_d    = 8'd0;
          state_d  = S_RD_ISSUE;
        end
      end
      S_RD_ISSUE: begin
        lat_d = lat_q + 8'd1;
        if (lat_q == LAT_LAST) begin
          capture = 1'b1;
          lat_d   = 8'd0;
          state_d = S_RD_HOLD;
        end
      end
      S_RD_HOLD: begin
        if (out_ready) begin
          ag_r_inc = 1'b1;
          state_d  = rd_last ? S_IDLE : S_RD_ISSUE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, command latch, wait/latency counters and read capture.
  always_ff @(posedge clk_processor or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      n_q        <= 10'd0;
      wcnt_q     <= 16'd0;
      lat_q      <= 8'd0;
      cmd_err_q  <= 1'b0;
      out_data_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      lat_q     <= lat_d;
      cmd_err_q <= cmd_err_d;
      if (latch_cmd) begin
        op_q <= cmd_decrypt;
        n_q  <= cmd_nblocks;
      end
      if (capture) out_data_q <= read_data;
    end
  end

  // Key words are pure data; they are always rewritten before use.
  always_ff @(posedge clk_processor) begin
    if (key_wr) key_q[w] <= in_data;
  end

  // Bridge and stream outputs decoded from the current state.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    aes_encrypt = 1'b0;
    aes_decrypt = 1'b0;
    write_en    = 1'b0;
    data_addr   = 17'd0;
    write_data  = 32'd0;
    no_of_words = RDSEL_OUT;
    key_addr    = KEY_BASE;
    write_addr  = OUT_BASE;
    case (state_q)
      S_KEY: in_ready = 1'b1;
      S_LOAD_D: begin
        in_ready   = 1'b1;
        write_en   = in_valid;
        data_addr  = {1'b0, data_wa};
        write_data = in_data;
      end
      S_LOAD_K: begin
        write_en               = 1'b1;
        data_addr              = {1'b0, key_wa};
        data_addr[KEY_SEL_BIT] = 1'b1;
        write_data             = key_q[w];
      end
      S_START: begin
        aes_decrypt = op_q;
        aes_encrypt = !op_q;
        no_of_words = n_q;
        data_addr   = {1'b0, DATA_BASE};
      end
      S_RD_ISSUE: begin
        no_of_words = RDSEL_OUT;
        data_addr   = {1'b0, out_ra};
      end
      S_RD_HOLD: begin
        out_valid = 1'b1;
        out_last  = rd_last;
      end
      default: ;
    endcase
  end

  assign out_data = out_data_q;
  assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_aes_job_driver.sv
// Self-checking bench for aes_job_driver: table of jobs plus hand-written
// reset-abort sequence, with write/read scoreboards and a timing monitor.
module tb_aes_job_driver;

  localparam int WAIT_BASE    = 32;
  localparam int WAIT_PER_BLK = 4;
  localparam int RD_LAT       = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_decrypt;
  logic [9:0]  cmd_nblocks;
  logic        cmd_ready, cmd_err;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [31:0] out_data;
  logic        busy, aes_encrypt, aes_decrypt, write_en;
  logic [16:0] data_addr;
  logic [15:0] key_addr, write_addr;
  logic [31:0] write_data;
  logic [9:0]  no_of_words;
  logic [31:0] read_data;

  always #5 clk = ~clk;

  aes_job_driver dut (
    .clk_processor (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_decrypt   (cmd_decrypt),
    .cmd_nblocks   (cmd_nblocks),
    .cmd_err       (cmd_err),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .aes_encrypt   (aes_encrypt),
    .aes_decrypt   (aes_decrypt),
    .write_en      (write_en),
    .data_addr     (data_addr),
    .key_addr      (key_addr),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .no_of_words   (no_of_words),
    .read_data     (read_data)
  );

  typedef struct packed { logic [16:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [31:0] d; logic last; } rd_t;
  typedef struct {
    logic       dec;
    logic [9:0] n;
    bit         gap;
    int         stall_idx;
    int         stall_len;
    bit         exp_err;
  } vec_t;

  wr_t wq[$];
  rd_t rq[$];

  int  n_vec = 0;
  int  n_miss = 0;
  int  cyc = 0;
  int  enc_cnt, dec_cnt, start_cyc, exp_lat;
  bit  ov_pend;
  logic       exp_dec;
  logic [9:0] exp_n;

  function automatic logic [31:0] out_word(input logic [16:0] a);
    return 32'hC0DE0000 | {15'd0, a};
  endfunction

  // Bridge read model: one register stage, address held for RD_LAT cycles
  always @(posedge clk)
    read_data <= (no_of_words == 10'd0) ? out_word(data_addr) : 32'hBAD0BAD0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_miss++;
    $display("FAIL %s: event occurred/expired, required otherwise", nm);
  endtask

  // Monitor: pops scoreboards and checks start pulse and hold behaviour
  initial begin
    bit          prev_hold;
    logic [31:0] prev_data;
    logic        prev_last;
    wr_t e;
    rd_t o;
    prev_hold = 0;
    prev_data = '0;
    prev_last = 0;
    ov_pend = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_hold = 0;
      end else begin
        if (write_en) begin
          if (wq.size() == 0) flag("unexpected_write");
          else begin
            e = wq.pop_front();
            chk("wr_addr", 64'(data_addr), 64'(e.a));
            chk("wr_data", 64'(write_data), 64'(e.d));
          end
        end
        if (aes_encrypt || aes_decrypt) begin
          chk("start_exclusive", 64'(aes_encrypt & aes_decrypt), 64'd0);
          chk("start_op", 64'(aes_decrypt), 64'(exp_dec));
          chk("start_nwords", 64'(no_of_words), 64'(exp_n));
          chk("start_addrs", 64'({data_addr, key_addr, write_addr}), 64'd0);
          chk("writes_done_at_start", 64'(wq.size()), 64'd0);
          if (aes_encrypt) enc_cnt++;
          if (aes_decrypt) dec_cnt++;
          start_cyc = cyc;
          ov_pend = 1;
        end
        if (out_valid && ov_pend) begin
          chk("start_to_valid", 64'(cyc - start_cyc), 64'(exp_lat));
          ov_pend = 0;
        end
        if (prev_hold) begin
          chk("hold_valid", 64'(out_valid), 64'd1);
          chk("hold_data", 64'(out_data), 64'(prev_data));
          chk("hold_last", 64'(out_last), 64'(prev_last));
        end
        if (out_valid && out_ready) begin
          if (rq.size() == 0) flag("unexpected_out");
          else begin
            o = rq.pop_front();
            chk("out_data", 64'(out_data), 64'(o.d));
            chk("out_last", 64'(out_last), 64'(o.last));
          end
        end
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        prev_last = out_last;
      end
    end
  end

  task automatic send_cmd(input logic dec, input logic [9:0] n);
    cmd_valid = 1'b1;
    cmd_decrypt = dec;
    cmd_nblocks = n;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] d);
    int guard;
    bit acc;
    guard = 0;
    acc = 0;
    in_data = d;
    in_valid = 1'b1;
    while (!acc && guard < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!acc) flag("in_accept_timeout");
  endtask

  task automatic push_job(input logic dec, input logic [9:0] n, input logic [31:0] key[4],
                          output logic [31:0] dw[$]);
    wr_t e;
    rd_t o;
    logic [31:0] v;
    dw.delete();
    for (int b = 0; b < int'(n); b++) begin
      for (int w = 0; w < 4; w++) begin
        v = $urandom;
        dw.push_back(v);
        e.a = {1'b0, 16'(16 * b + 4 * w)};
        e.d = v;
        wq.push_back(e);
      end
      for (int w = 0; w < 4; w++) begin
        e.a = {1'b1, 16'(16 * b + 4 * w)};
        e.d = key[w];
        wq.push_back(e);
      end
    end
    for (int r = 0; r < 4 * int'(n); r++) begin
      o.d = out_word({1'b0, 16'(4 * r)});
      o.last = (r == 4 * int'(n) - 1);
      rq.push_back(o);
    end
    exp_dec = dec;
    exp_n = n;
    exp_lat = WAIT_BASE + int'(n) * WAIT_PER_BLK + 1 + RD_LAT;
    enc_cnt = 0;
    dec_cnt = 0;
  endtask

  task automatic run_job(input logic dec, input logic [9:0] n, input bit gap,
                         input int stall_idx, input int stall_len, input bit tp_key);
    logic [31:0] key [4];
    logic [31:0] dw[$];
    int guard;
    if (tp_key) key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c};
    else for (int i = 0; i < 4; i++) key[i] = $urandom;
    push_job(dec, n, key, dw);
    send_cmd(dec, n);
    for (int i = 0; i < 4; i++) begin
      send_word(key[i]);
      if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    foreach (dw[i]) begin
      send_word(dw[i]);
      if (gap) begin in_valid = 1'b0; @(posedge clk); #1; end
    end
    in_valid = 1'b0;
    for (int r = 0; r < 4 * int'(n); r++) begin
      out_ready = (r == stall_idx) ? 1'b0 : 1'b1;
      guard = 0;
      do begin @(negedge clk); guard++; end while (!out_valid && guard < 2000);
      if (!out_valid) begin flag("out_valid_timeout"); break; end
      if (r == stall_idx) begin
        repeat (stall_len) @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (busy && guard < 50);
    chk("job_idle", 64'(busy), 64'd0);
    chk("wr_queue_empty", 64'(wq.size()), 64'd0);
    chk("rd_queue_empty", 64'(rq.size()), 64'd0);
    chk("enc_pulses", 64'(enc_cnt), dec ? 64'd0 : 64'd1);
    chk("dec_pulses", 64'(dec_cnt), dec ? 64'd1 : 64'd0);
  endtask

  task automatic run_err(input logic dec, input logic [9:0] n);
    int ec, bc;
    ec = 0;
    bc = 0;
    send_cmd(dec, n);
    repeat (4) begin
      @(negedge clk);
      ec += int'(cmd_err);
      bc += int'(busy);
    end
    chk("cmd_err_pulse", 64'(ec), 64'd1);
    chk("busy_on_err", 64'(bc), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    logic [31:0] key [4];
    logic [31:0] dw[$];

    vecs[0] = '{dec: 1'b0, n: 10'd1,    gap: 0, stall_idx: -1, stall_len: 0, exp_err: 0};
    vecs[1] = '{dec: 1'b1, n: 10'd3,    gap: 1, stall_idx: -1, stall_len: 0, exp_err: 0};
    vecs[2] = '{dec: 1'b0, n: 10'd0,    gap: 0, stall_idx: -1, stall_len: 0, exp_err: 1};
    vecs[3] = '{dec: 1'b0, n: 10'd65,   gap: 0, stall_idx: -1, stall_len: 0, exp_err: 1};
    vecs[4] = '{dec: 1'b0, n: 10'd2,    gap: 0, stall_idx: 2,  stall_len: 5, exp_err: 0};
    vecs[5] = '{dec: 1'b1, n: 10'd64,   gap: 0, stall_idx: -1, stall_len: 0, exp_err: 0};
    vecs[6] = '{dec: 1'b1, n: 10'd1023, gap: 0, stall_idx: -1, stall_len: 0, exp_err: 1};

    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_decrypt = 1'b0;
    cmd_nblocks = 10'd0;
    in_valid = 1'b0;
    in_data = 32'd0;
    out_ready = 1'b1;
    enc_cnt = 0;
    dec_cnt = 0;
    exp_dec = 1'b0;
    exp_n = 10'd0;
    exp_lat = 0;
    start_cyc = 0;

    #12;
    chk("reset_ctrl", 64'({cmd_ready, busy, in_ready, out_valid, write_en,
                           aes_encrypt, aes_decrypt, cmd_err, out_last}), 64'h100);
    chk("reset_buses", 64'({data_addr, no_of_words, out_data}), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err) run_err(vecs[i].dec, vecs[i].n);
      else run_job(vecs[i].dec, vecs[i].n, vecs[i].gap,
                   vecs[i].stall_idx, vecs[i].stall_len, i == 0);
    end

    // Reset during LOAD_K aborts the job with no further writes or start
    for (int i = 0; i < 4; i++) key[i] = $urandom;
    push_job(1'b0, 10'd2, key, dw);
    send_cmd(1'b0, 10'd2);
    for (int i = 0; i < 4; i++) send_word(key[i]);
    for (int i = 0; i < 4; i++) send_word(dw[i]);
    @(negedge clk);
    chk("in_load_k", 64'({in_ready, write_en, data_addr[16]}), 64'h3);
    #2 reset = 1'b1;
    #1;
    chk("rst_async_outputs", 64'({write_en, busy, in_ready, cmd_ready, data_addr}),
        64'({1'b0, 1'b0, 1'b0, 1'b1, 17'd0}));
    @(posedge clk); #1;
    reset = 1'b0;
    in_valid = 1'b0;
    wq.delete();
    rq.delete();
    repeat (80) @(posedge clk);
    #1;
    chk("no_start_after_abort", 64'(enc_cnt + dec_cnt), 64'd0);
    chk("idle_after_abort", 64'({busy, cmd_ready}), 64'h1);
    run_job(1'b0, 10'd2, 0, -1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
